// File: rtl/sdma_sap_padding_scanner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sdma_sap_padding_scanner
// Description : Walks the padded/upsampled destination window in x, y, c
//               order. For each position it emits a beat with coordinates, a
//               padding flag and a source-read strobe, under valid/ready flow
//               control.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

// Width defaults, used only when nsdm.vh has not already provided them.
`ifndef SDMA_INST_PADDINGLEFTXWIDTH
`define SDMA_INST_PADDINGLEFTXWIDTH 4
`endif
`ifndef SDMA_INST_PADDINGRIGHTXWIDTH
`define SDMA_INST_PADDINGRIGHTXWIDTH 4
`endif
`ifndef SDMA_INST_PADDINGLEFTYWIDTH
`define SDMA_INST_PADDINGLEFTYWIDTH 4
`endif
`ifndef SDMA_INST_PADDINGRIGHTYWIDTH
`define SDMA_INST_PADDINGRIGHTYWIDTH 4
`endif
`ifndef SDMA_INST_INSERTZERONUMTOTALXWIDTH
`define SDMA_INST_INSERTZERONUMTOTALXWIDTH 4
`endif
`ifndef SDMA_INST_INSERTZERONUMTOTALYWIDTH
`define SDMA_INST_INSERTZERONUMTOTALYWIDTH 4
`endif
`ifndef SDMA_INST_SRCFMSCWIDTH
`define SDMA_INST_SRCFMSCWIDTH 8
`endif
`ifndef SDMA_INST_SRCFMSXWIDTH
`define SDMA_INST_SRCFMSXWIDTH 8
`endif
`ifndef SDMA_INST_SRCFMSYWIDTH
`define SDMA_INST_SRCFMSYWIDTH 8
`endif

module sdma_sap_padding_scanner (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_sap_ps_start,
    input  logic                                          i_sap_ps_paddingen,
    input  logic                                          i_sap_ps_upsampleen,
    input  logic [`SDMA_INST_PADDINGLEFTXWIDTH-1:0]        i_sap_ps_paddingleftx,
    input  logic [`SDMA_INST_PADDINGRIGHTXWIDTH-1:0]       i_sap_ps_paddingrightx,
    input  logic [`SDMA_INST_PADDINGLEFTYWIDTH-1:0]        i_sap_ps_paddinglefty,
    input  logic [`SDMA_INST_PADDINGRIGHTYWIDTH-1:0]       i_sap_ps_paddingrighty,
    input  logic [`SDMA_INST_INSERTZERONUMTOTALXWIDTH-1:0] i_sap_ps_insertzeronumtotalx,
    input  logic [`SDMA_INST_INSERTZERONUMTOTALYWIDTH-1:0] i_sap_ps_insertzeronumtotaly,
    input  logic [`SDMA_INST_SRCFMSCWIDTH-1:0]             i_sap_ps_srcfmsc,
    input  logic [`SDMA_INST_SRCFMSXWIDTH-1:0]             i_sap_ps_srcfmsx,
    input  logic [`SDMA_INST_SRCFMSYWIDTH-1:0]             i_sap_ps_srcfmsy,
    input  logic                                          i_sap_ps_ready,
    output logic                                          o_sap_ps_valid,
    output logic [`SDMA_INST_SRCFMSCWIDTH-1:0]             o_sap_ps_sfmsccnt,
    output logic [`SDMA_INST_SRCFMSXWIDTH-1:0]             o_sap_ps_sfmsxcnt,
    output logic [`SDMA_INST_SRCFMSYWIDTH-1:0]             o_sap_ps_sfmsycnt,
    output logic                                          o_sap_ps_padding_flag,
    output logic                                          o_sap_ps_src_rd,
    output logic                                          o_sap_ps_busy,
    output logic                                          o_sap_ps_done
);

    localparam int c_CW   = `SDMA_INST_SRCFMSCWIDTH;
    localparam int c_XW   = `SDMA_INST_SRCFMSXWIDTH;
    localparam int c_YW   = `SDMA_INST_SRCFMSYWIDTH;
    // Bounds carry one extra bit so pad + size + zeros never wraps before compare.
    localparam int c_XB_W = c_XW + 1;
    localparam int c_YB_W = c_YW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_CW-1:0]     ccnt_q, ccnt_d;
    logic [c_XW-1:0]     xcnt_q, xcnt_d;
    logic [c_YW-1:0]     ycnt_q, ycnt_d;
    logic                flag_q, flag_d;
    logic                w_cfg_ld;

    // Latched scan configuration (effective values, already gated by enables)
    logic                pe_q;
    logic [c_XB_W-1:0]   lx_q, bx_q, ex_q;
    logic [c_YB_W-1:0]   ly_q, by_q, ey_q;
    logic [c_CW-1:0]     ec_q;

    // Configuration as seen on the inputs, used in the start cycle
    logic [c_XB_W-1:0]   w_lx_in, w_rx_in, w_zx_in, w_bx_in, w_ex_in;
    logic [c_YB_W-1:0]   w_ly_in, w_ry_in, w_zy_in, w_by_in, w_ey_in;
    logic                w_zero_in;

    // Counter stepping
    logic                w_x_wrap, w_y_wrap, w_c_wrap, w_last;
    logic [c_XW-1:0]     w_x_nxt;
    logic [c_YW-1:0]     w_y_nxt;
    logic [c_CW-1:0]     w_c_nxt;

    // Position lies in the left/right/top/bottom padding band
    function automatic logic f_pad(
        input logic              en,
        input logic [c_XW-1:0]   x,
        input logic [c_YW-1:0]   y,
        input logic [c_XB_W-1:0] lx,
        input logic [c_XB_W-1:0] bx,
        input logic [c_YB_W-1:0] ly,
        input logic [c_YB_W-1:0] by
    );
        logic [c_XB_W-1:0] xe;
        logic [c_YB_W-1:0] ye;
        xe = {1'b0, x};
        ye = {1'b0, y};
        return en & ((xe < lx) | (xe >= bx) | (ye < ly) | (ye >= by));
    endfunction

    assign w_lx_in   = i_sap_ps_paddingen  ? c_XB_W'(i_sap_ps_paddingleftx)        : '0;
    assign w_rx_in   = i_sap_ps_paddingen  ? c_XB_W'(i_sap_ps_paddingrightx)       : '0;
    assign w_ly_in   = i_sap_ps_paddingen  ? c_YB_W'(i_sap_ps_paddinglefty)        : '0;
    assign w_ry_in   = i_sap_ps_paddingen  ? c_YB_W'(i_sap_ps_paddingrighty)       : '0;
    assign w_zx_in   = i_sap_ps_upsampleen ? c_XB_W'(i_sap_ps_insertzeronumtotalx) : '0;
    assign w_zy_in   = i_sap_ps_upsampleen ? c_YB_W'(i_sap_ps_insertzeronumtotaly) : '0;
    assign w_bx_in   = w_lx_in + c_XB_W'(i_sap_ps_srcfmsx) + w_zx_in;
    assign w_ex_in   = w_bx_in + w_rx_in;
    assign w_by_in   = w_ly_in + c_YB_W'(i_sap_ps_srcfmsy) + w_zy_in;
    assign w_ey_in   = w_by_in + w_ry_in;
    assign w_zero_in = (w_ex_in == '0) | (w_ey_in == '0) | (i_sap_ps_srcfmsc == '0);

    assign w_x_wrap = (c_XB_W'(xcnt_q) + c_XB_W'(1)) >= ex_q;
    assign w_y_wrap = (c_YB_W'(ycnt_q) + c_YB_W'(1)) >= ey_q;
    assign w_c_wrap = (ccnt_q + c_CW'(1)) == ec_q;
    assign w_last   = w_x_wrap & w_y_wrap & w_c_wrap;
    assign w_x_nxt  = w_x_wrap ? '0 : xcnt_q + c_XW'(1);
    assign w_y_nxt  = w_x_wrap ? (w_y_wrap ? '0 : ycnt_q + c_YW'(1)) : ycnt_q;
    assign w_c_nxt  = (w_x_wrap & w_y_wrap) ? ccnt_q + c_CW'(1) : ccnt_q;

    // Next-state, next-coordinate and configuration-load decode
    always_comb begin
        state_d  = state_q;
        xcnt_d   = xcnt_q;
        ycnt_d   = ycnt_q;
        ccnt_d   = ccnt_q;
        flag_d   = flag_q;
        w_cfg_ld = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_sap_ps_start) begin
                    w_cfg_ld = 1'b1;
                    xcnt_d   = '0;
                    ycnt_d   = '0;
                    ccnt_d   = '0;
                    if (w_zero_in) begin
                        state_d = ST_DONE;
                        flag_d  = 1'b0;
                    end else begin
                        state_d = ST_SCAN;
                        flag_d  = f_pad(i_sap_ps_paddingen, '0, '0,
                                        w_lx_in, w_bx_in, w_ly_in, w_by_in);
                    end
                end
            end
            ST_SCAN: begin
                if (i_sap_ps_ready) begin
                    if (w_last) begin
                        state_d = ST_DONE;
                        xcnt_d  = '0;
                        ycnt_d  = '0;
                        ccnt_d  = '0;
                        flag_d  = 1'b0;
                    end else begin
                        xcnt_d  = w_x_nxt;
                        ycnt_d  = w_y_nxt;
                        ccnt_d  = w_c_nxt;
                        flag_d  = f_pad(pe_q, w_x_nxt, w_y_nxt, lx_q, bx_q, ly_q, by_q);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Beat coordinates and their padding flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            xcnt_q <= '0;
            ycnt_q <= '0;
            ccnt_q <= '0;
            flag_q <= 1'b0;
        end else begin
            xcnt_q <= xcnt_d;
            ycnt_q <= ycnt_d;
            ccnt_q <= ccnt_d;
            flag_q <= flag_d;
        end
    end

    // Configuration snapshot taken on an accepted start
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pe_q <= 1'b0;
            lx_q <= '0;
            bx_q <= '0;
            ex_q <= '0;
            ly_q <= '0;
            by_q <= '0;
            ey_q <= '0;
            ec_q <= '0;
        end else if (w_cfg_ld) begin
            pe_q <= i_sap_ps_paddingen;
            lx_q <= w_lx_in;
            bx_q <= w_bx_in;
            ex_q <= w_ex_in;
            ly_q <= w_ly_in;
            by_q <= w_by_in;
            ey_q <= w_ey_in;
            ec_q <= i_sap_ps_srcfmsc;
        end
    end

    assign o_sap_ps_valid        = (state_q == ST_SCAN);
    assign o_sap_ps_busy         = (state_q == ST_SCAN);
    assign o_sap_ps_done         = (state_q == ST_DONE);
    assign o_sap_ps_sfmsccnt     = ccnt_q;
    assign o_sap_ps_sfmsxcnt     = xcnt_q;
    assign o_sap_ps_sfmsycnt     = ycnt_q;
    assign o_sap_ps_padding_flag = flag_q;
    assign o_sap_ps_src_rd       = o_sap_ps_valid & ~flag_q;

endmodule

`default_nettype wire

// File: tb/tb_sdma_sap_padding_scanner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_sdma_sap_padding_scanner
// Description : Directed bench for the padding scanner; expected beats are
//               generated from the window formulas into a queue and popped on
//               each handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

`ifndef SDMA_INST_PADDINGLEFTXWIDTH
`define SDMA_INST_PADDINGLEFTXWIDTH 4
`endif
`ifndef SDMA_INST_PADDINGRIGHTXWIDTH
`define SDMA_INST_PADDINGRIGHTXWIDTH 4
`endif
`ifndef SDMA_INST_PADDINGLEFTYWIDTH
`define SDMA_INST_PADDINGLEFTYWIDTH 4
`endif
`ifndef SDMA_INST_PADDINGRIGHTYWIDTH
`define SDMA_INST_PADDINGRIGHTYWIDTH 4
`endif
`ifndef SDMA_INST_INSERTZERONUMTOTALXWIDTH
`define SDMA_INST_INSERTZERONUMTOTALXWIDTH 4
`endif
`ifndef SDMA_INST_INSERTZERONUMTOTALYWIDTH
`define SDMA_INST_INSERTZERONUMTOTALYWIDTH 4
`endif
`ifndef SDMA_INST_SRCFMSCWIDTH
`define SDMA_INST_SRCFMSCWIDTH 8
`endif
`ifndef SDMA_INST_SRCFMSXWIDTH
`define SDMA_INST_SRCFMSXWIDTH 8
`endif
`ifndef SDMA_INST_SRCFMSYWIDTH
`define SDMA_INST_SRCFMSYWIDTH 8
`endif

module tb_sdma_sap_padding_scanner;

    localparam int c_CW  = `SDMA_INST_SRCFMSCWIDTH;
    localparam int c_XW  = `SDMA_INST_SRCFMSXWIDTH;
    localparam int c_YW  = `SDMA_INST_SRCFMSYWIDTH;
    localparam int c_LXW = `SDMA_INST_PADDINGLEFTXWIDTH;
    localparam int c_RXW = `SDMA_INST_PADDINGRIGHTXWIDTH;
    localparam int c_LYW = `SDMA_INST_PADDINGLEFTYWIDTH;
    localparam int c_RYW = `SDMA_INST_PADDINGRIGHTYWIDTH;
    localparam int c_ZXW = `SDMA_INST_INSERTZERONUMTOTALXWIDTH;
    localparam int c_ZYW = `SDMA_INST_INSERTZERONUMTOTALYWIDTH;

    logic              clk = 1'b0;
    logic              rst, start, pe, ue, ready;
    logic [c_LXW-1:0]  lx;
    logic [c_RXW-1:0]  rx;
    logic [c_LYW-1:0]  ly;
    logic [c_RYW-1:0]  ry;
    logic [c_ZXW-1:0]  zx;
    logic [c_ZYW-1:0]  zy;
    logic [c_CW-1:0]   sc;
    logic [c_XW-1:0]   sx;
    logic [c_YW-1:0]   sy;

    logic              o_valid, o_flag, o_src_rd, o_busy, o_done;
    logic [c_CW-1:0]   o_c;
    logic [c_XW-1:0]   o_x;
    logic [c_YW-1:0]   o_y;

    typedef struct packed {
        logic [c_CW-1:0] c;
        logic [c_XW-1:0] x;
        logic [c_YW-1:0] y;
        logic            f;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    src_cnt;

    always #5 clk = ~clk;

    sdma_sap_padding_scanner dut (
        .i_clk                        (clk),
        .i_rst                        (rst),
        .i_sap_ps_start               (start),
        .i_sap_ps_paddingen           (pe),
        .i_sap_ps_upsampleen          (ue),
        .i_sap_ps_paddingleftx        (lx),
        .i_sap_ps_paddingrightx       (rx),
        .i_sap_ps_paddinglefty        (ly),
        .i_sap_ps_paddingrighty       (ry),
        .i_sap_ps_insertzeronumtotalx (zx),
        .i_sap_ps_insertzeronumtotaly (zy),
        .i_sap_ps_srcfmsc             (sc),
        .i_sap_ps_srcfmsx             (sx),
        .i_sap_ps_srcfmsy             (sy),
        .i_sap_ps_ready               (ready),
        .o_sap_ps_valid               (o_valid),
        .o_sap_ps_sfmsccnt            (o_c),
        .o_sap_ps_sfmsxcnt            (o_x),
        .o_sap_ps_sfmsycnt            (o_y),
        .o_sap_ps_padding_flag        (o_flag),
        .o_sap_ps_src_rd              (o_src_rd),
        .o_sap_ps_busy                (o_busy),
        .o_sap_ps_done                (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int c, input int x, input int y, input bit p,
                           input int l_x, input int r_x, input int l_y, input int r_y,
                           input bit u, input int z_x, input int z_y);
        sc = c_CW'(c);   sx = c_XW'(x);   sy = c_YW'(y);
        pe = p;          ue = u;
        lx = c_LXW'(l_x); rx = c_RXW'(r_x); ly = c_LYW'(l_y); ry = c_RYW'(r_y);
        zx = c_ZXW'(z_x); zy = c_ZYW'(z_y);
    endtask

    // Expected beat list from the current configuration inputs
    task automatic push_model();
        int    l_x, r_x, l_y, r_y, z_x, z_y, b_x, e_x, b_y, e_y, e_c;
        beat_t b;
        l_x = pe ? int'(lx) : 0;  r_x = pe ? int'(rx) : 0;
        l_y = pe ? int'(ly) : 0;  r_y = pe ? int'(ry) : 0;
        z_x = ue ? int'(zx) : 0;  z_y = ue ? int'(zy) : 0;
        b_x = l_x + int'(sx) + z_x;  e_x = b_x + r_x;
        b_y = l_y + int'(sy) + z_y;  e_y = b_y + r_y;
        e_c = int'(sc);
        for (int c = 0; c < e_c; c++)
            for (int y = 0; y < e_y; y++)
                for (int x = 0; x < e_x; x++) begin
                    b.c = c_CW'(c);
                    b.x = c_XW'(x);
                    b.y = c_YW'(y);
                    b.f = pe && (x < l_x || x >= b_x || y < l_y || y >= b_y);
                    exp_q.push_back(b);
                end
    endtask

    // Runs one scan from the current negedge; rdy_mode 1 = ready 1,0,0,1 repeating
    task automatic run_scan(input string name, input int rdy_mode, input bit poke_start,
                            input bit scramble, output int n_src);
        int    last_hs;
        bit    got_done;
        beat_t e;
        push_model();
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            sx = ~sx; lx = ~lx; pe = ~pe; sc = sc + c_CW'(1); ue = ~ue;
        end
        chk({name, " first valid"}, 32'(o_valid), 32'(exp_q.size() != 0));
        last_hs  = -1;
        n_src    = 0;
        got_done = 1'b0;
        for (int i = 0; i < 400 && !got_done; i++) begin
            ready = (rdy_mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
            start = (poke_start && i == 1);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk({name, " extra beat"}, 32'(o_valid), 32'(0));
                    break;
                end
                e = exp_q[0];
                chk({name, " c"},      32'(o_c),      32'(e.c));
                chk({name, " x"},      32'(o_x),      32'(e.x));
                chk({name, " y"},      32'(o_y),      32'(e.y));
                chk({name, " flag"},   32'(o_flag),   32'(e.f));
                chk({name, " src_rd"}, 32'(o_src_rd), 32'(!e.f));
                chk({name, " busy"},   32'(o_busy),   32'(1));
                if (ready) begin
                    void'(exp_q.pop_front());
                    last_hs = i;
                    if (o_src_rd) n_src++;
                end
            end
            if (o_done) begin
                got_done = 1'b1;
                chk({name, " done timing"},  32'(i),             32'(last_hs + 1));
                chk({name, " beats left"},   32'(exp_q.size()), 32'(0));
                chk({name, " valid in done"}, 32'(o_valid),      32'(0));
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, " timeout"}, 32'(got_done), 32'(1));
        chk({name, " idle valid"}, 32'(o_valid), 32'(0));
        chk({name, " idle done"},  32'(o_done),  32'(0));
        @(negedge clk);
        chk({name, " no queued start"}, 32'(o_busy), 32'(0));
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("reset valid",  32'(o_valid),  32'(0));
        chk("reset busy",   32'(o_busy),   32'(0));
        chk("reset done",   32'(o_done),   32'(0));
        chk("reset flag",   32'(o_flag),   32'(0));
        chk("reset src_rd", 32'(o_src_rd), 32'(0));
        chk("reset xyc",    32'({o_c, o_x, o_y}), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // No padding: 2x2 plain walk
        set_cfg(1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        run_scan("nopad", 0, 1'b0, 1'b0, src_cnt);
        chk("nopad src_rd count", 32'(src_cnt), 32'(4));

        // Padding with inputs scrambled after start
        set_cfg(1, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        run_scan("pad", 0, 1'b0, 1'b1, src_cnt);
        chk("pad src_rd count", 32'(src_cnt), 32'(2));

        // Upsample: inserted zeros are not padding
        set_cfg(1, 2, 1, 0, 3, 3, 3, 3, 1, 1, 0);
        run_scan("ups", 0, 1'b0, 1'b0, src_cnt);
        chk("ups src_rd count", 32'(src_cnt), 32'(3));

        // Backpressure with a stray start mid-scan
        set_cfg(1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        run_scan("bp", 1, 1'b1, 1'b0, src_cnt);
        chk("bp src_rd count", 32'(src_cnt), 32'(4));

        // Padding, multi-channel, backpressure
        set_cfg(2, 1, 1, 1, 1, 2, 0, 1, 1, 1, 1);
        run_scan("padc2", 1, 1'b0, 1'b0, src_cnt);
        chk("padc2 src_rd count", 32'(src_cnt), 32'(8));

        // Zero channel count: straight to done
        set_cfg(0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        run_scan("zero", 0, 1'b0, 1'b0, src_cnt);

        // Reset mid-scan after two beats
        set_cfg(1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst beat0 x", 32'(o_x), 32'(0));
        @(negedge clk);
        chk("rst beat1 x", 32'(o_x), 32'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst abort valid", 32'(o_valid), 32'(0));
        chk("rst abort busy",  32'(o_busy),  32'(0));
        chk("rst abort done",  32'(o_done),  32'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst no done", 32'(o_done), 32'(0));
        end
        run_scan("rescan", 0, 1'b0, 1'b0, src_cnt);
        chk("rescan src_rd count", 32'(src_cnt), 32'(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
